// File: rtl/sfx_audio_pkg.sv
// Shared types and constants for the sound-effect output stage.
package sfx_audio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  localparam int         PWM_W      = 8;
  localparam logic [7:0] SAMPLE_MID = 8'd128;
  localparam logic [7:0] ENV_MAX    = 8'd255;

endpackage

// File: rtl/sfx_envelope.sv
// Attack/sustain/release envelope driven by edges on the raw square wave.
// Release starts once no edge has been seen for IDLE_TIMEOUT cycles.
module sfx_envelope
  import sfx_audio_pkg::*;
#(
  parameter int ENV_DIV      = 256,
  parameter int IDLE_TIMEOUT = 200000,
  parameter int TO_W         = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sound,
  output logic [7:0] env,
  output logic       active
);

  localparam int              DIV_W    = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ENV_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(IDLE_TIMEOUT);

  logic             sound_d;
  logic             activity;
  logic             timeout;
  logic             tick;
  logic [TO_W-1:0]  idle_cnt;
  logic [DIV_W-1:0] div_cnt;
  env_state_t       state;
  env_state_t       state_next;
  logic [7:0]       env_next;

  assign activity = sound ^ sound_d;
  assign timeout  = (idle_cnt == TO_LIMIT);
  assign tick     = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sound_d  <= 1'b0;
      idle_cnt <= '0;
      div_cnt  <= '0;
    end else begin
      sound_d <= sound;
      if (activity)
        idle_cnt <= '0;
      else if (!timeout)
        idle_cnt <= idle_cnt + TO_W'(1);
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      env    <= '0;
      active <= 1'b0;
    end else begin
      state  <= state_next;
      env    <= env_next;
      active <= (state_next != IDLE);
    end
  end

  // A tick step is applied in the same cycle as any state change.
  always_comb begin
    env_next = env;
    case (state)
      IDLE:    env_next = '0;
      ATTACK:  if (tick && env != ENV_MAX) env_next = env + 8'd1;
      SUSTAIN: env_next = ENV_MAX;
      RELEASE: if (tick && env != 8'd0) env_next = env - 8'd1;
      default: env_next = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (activity) state_next = ATTACK;
      ATTACK: begin
        if (timeout && !activity)    state_next = RELEASE;
        else if (env_next == ENV_MAX) state_next = SUSTAIN;
      end
      SUSTAIN: if (timeout && !activity) state_next = RELEASE;
      RELEASE: begin
        if (activity)              state_next = ATTACK;
        else if (env_next == 8'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/sfx_audio_out.sv
// Speaker output stage: envelope and volume shaping, offset-binary sample, PWM drive.
// The sample only changes at PWM frame boundaries, flagged by a one-cycle sample_valid.
module sfx_audio_out
  import sfx_audio_pkg::*;
#(
  parameter int ENV_DIV      = 256,
  parameter int IDLE_TIMEOUT = 200000,
  parameter int TO_W         = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sound,
  input  logic [3:0] volume,
  input  logic       mute,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       pwm_out,
  output logic       active
);

  logic [7:0]       env;
  logic [11:0]      prod;
  logic [6:0]       amp;
  logic [7:0]       sample_next;
  logic [7:0]       sample_next_q;
  logic [PWM_W-1:0] pwm_cnt;

  sfx_envelope #(
    .ENV_DIV      (ENV_DIV),
    .IDLE_TIMEOUT (IDLE_TIMEOUT),
    .TO_W         (TO_W)
  ) u_env (
    .clk    (clk),
    .reset  (reset),
    .sound  (sound),
    .env    (env),
    .active (active)
  );

  // 255*15 >> 5 = 119, so 128 +/- amp stays inside 9..247.
  assign prod = {4'd0, env} * {8'd0, volume};
  assign amp  = prod[11:5];

  always_comb begin
    sample_next = SAMPLE_MID;
    if (!mute && volume != 4'd0)
      sample_next = sound ? (SAMPLE_MID + {1'b0, amp}) : (SAMPLE_MID - {1'b0, amp});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_next_q <= SAMPLE_MID;
      pwm_cnt       <= '0;
      sample        <= SAMPLE_MID;
      sample_valid  <= 1'b0;
      pwm_out       <= 1'b0;
    end else begin
      sample_next_q <= sample_next;
      pwm_cnt       <= pwm_cnt + PWM_W'(1);
      sample_valid  <= (pwm_cnt == '1);
      if (pwm_cnt == '1)
        sample <= sample_next_q;
      pwm_out <= (pwm_cnt < sample);
    end
  end

endmodule
